// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-driven clock-gate controller for a cluster clock domain.
// It runs on the free-running clock and negotiates stop/wake with the cluster.
module cluster_clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic test_en_i,
    input  logic busy_i,
    input  logic wake_i,
    input  logic stop_ack_i,
    output logic clk_en_o,
    output logic stop_req_o,
    output logic gated_o
);

    localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle
        $error("cluster_clock_gate_ctrl: IDLE_CYCLES must be in 1..255");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
        $error("cluster_clock_gate_ctrl: WAKE_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_COUNT    = 3'd1,
        ST_STOP_REQ = 3'd2,
        ST_GATED    = 3'd3,
        ST_WAKE     = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic          clk_en_reg, stop_req_reg, gated_reg;
    logic          clk_en_next, stop_req_next, gated_next;
    logic          idle;

    assign idle    = !busy_i && !wake_i;
    assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;

    // Outputs are registered copies of the decode of the next state, so they
    // change on the same edge as the state and never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_RUN;
            cnt_reg      <= '0;
            clk_en_reg   <= 1'b1;
            stop_req_reg <= 1'b0;
            gated_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clk_en_reg   <= clk_en_next;
            stop_req_reg <= stop_req_next;
            gated_reg    <= gated_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (test_en_i) begin
            state_next = ST_RUN;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    cnt_next = '0;
                    if (idle) state_next = ST_COUNT;
                end
                ST_COUNT: begin
                    if (!idle) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else if (cnt_reg == IDLE_LAST) begin
                        state_next = ST_STOP_REQ;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                // Activity beats an acknowledge arriving in the same cycle.
                ST_STOP_REQ: begin
                    if (!idle) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else if (stop_ack_i) begin
                        state_next = ST_GATED;
                    end
                end
                ST_GATED: begin
                    if (busy_i || wake_i) begin
                        state_next = ST_WAKE;
                        cnt_next   = '0;
                    end
                end
                ST_WAKE: begin
                    if (cnt_reg == WAKE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        clk_en_next   = 1'b1;
        stop_req_next = 1'b0;
        gated_next    = 1'b0;
        case (state_next)
            ST_STOP_REQ: stop_req_next = 1'b1;
            ST_GATED: begin
                clk_en_next   = 1'b0;
                stop_req_next = 1'b1;
                gated_next    = 1'b1;
            end
            ST_WAKE:     stop_req_next = 1'b1;
            default:     ;
        endcase
    end

    assign clk_en_o   = clk_en_reg;
    assign stop_req_o = stop_req_reg;
    assign gated_o    = gated_reg;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Directed bench for cluster_clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_cluster_clock_gate_ctrl;

    logic clk_i = 1'b0;
    logic rst_ni, test_en_i, busy_i, wake_i, stop_ack_i;
    logic clk_en_o, stop_req_o, gated_o;

    int errors = 0;
    int checks = 0;

    cluster_clock_gate_ctrl #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .test_en_i  (test_en_i),
        .busy_i     (busy_i),
        .wake_i     (wake_i),
        .stop_ack_i (stop_ack_i),
        .clk_en_o   (clk_en_o),
        .stop_req_o (stop_req_o),
        .gated_o    (gated_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; test_en_i = 1'b0; busy_i = 1'b1; wake_i = 1'b0; stop_ack_i = 1'b0;
        #12;
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_run got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        $display("test_reset done");
    endtask

    // Busy dropped right after edge 0; stop_req rises after edge 5, ack after edge 7 gates at edge 8.
    task automatic test_idle_to_gated();
        busy_i = 1'b1;
        tick();
        busy_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (stop_req_o !== (i == 5) || clk_en_o !== 1'b1) begin
                errors++;
                $display("FAIL idle_edge%0d stop_req=%b clk_en=%b exp stop_req=%b clk_en=1",
                         i, stop_req_o, clk_en_o, (i == 5));
            end
        end
        tick();
        tick();
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b011) begin
            errors++;
            $display("FAIL gated_entry got=%b exp=011", {clk_en_o, stop_req_o, gated_o});
        end
        $display("test_idle_to_gated done");
    endtask

    // In GATED: ack is ignored, a one-cycle wake gives two WAKE cycles then RUN.
    task automatic test_wake();
        stop_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({clk_en_o, stop_req_o, gated_o} !== 3'b011) begin
                errors++;
                $display("FAIL gated_ack_ignored got=%b exp=011", {clk_en_o, stop_req_o, gated_o});
            end
        end
        stop_ack_i = 1'b0;
        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b110) begin
            errors++;
            $display("FAIL wake_cycle1 got=%b exp=110", {clk_en_o, stop_req_o, gated_o});
        end
        tick();
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b110) begin
            errors++;
            $display("FAIL wake_cycle2 got=%b exp=110", {clk_en_o, stop_req_o, gated_o});
        end
        tick();
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL wake_to_run got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        busy_i = 1'b1;
        tick();
        $display("test_wake done");
    endtask

    // Three idle cycles, one busy cycle, then the full idle count must restart.
    task automatic test_count_restart();
        busy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (stop_req_o !== 1'b0) begin
                errors++;
                $display("FAIL restart_pre%0d stop_req=%b exp=0", i, stop_req_o);
            end
        end
        busy_i = 1'b1;
        tick();
        busy_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (stop_req_o !== (i == 5)) begin
                errors++;
                $display("FAIL restart_edge%0d stop_req=%b exp=%b", i, stop_req_o, (i == 5));
            end
        end
        busy_i = 1'b1;
        tick();
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL stopreq_withdraw got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        $display("test_count_restart done");
    endtask

    // Wake and ack together in STOP_REQ: wake wins, the clock never stops.
    task automatic test_wake_ack_collision();
        busy_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stop_req_o !== 1'b1) begin
            errors++;
            $display("FAIL collision_setup stop_req=%b exp=1", stop_req_o);
        end
        wake_i = 1'b1;
        stop_ack_i = 1'b1;
        tick();
        wake_i = 1'b0;
        stop_ack_i = 1'b0;
        busy_i = 1'b1;
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL collision_run got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gated_o !== 1'b0 || clk_en_o !== 1'b1) begin
                errors++;
                $display("FAIL collision_hold gated=%b clk_en=%b exp gated=0 clk_en=1", gated_o, clk_en_o);
            end
        end
        $display("test_wake_ack_collision done");
    endtask

    task automatic go_gated();
        busy_i = 1'b0; wake_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        stop_ack_i = 1'b1;
        tick();
        stop_ack_i = 1'b0;
        checks++;
        if (gated_o !== 1'b1 || clk_en_o !== 1'b0) begin
            errors++;
            $display("FAIL go_gated gated=%b clk_en=%b exp gated=1 clk_en=0", gated_o, clk_en_o);
        end
    endtask

    task automatic test_test_en();
        go_gated();
        test_en_i = 1'b1;
        tick();
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL test_en_ungate got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        for (int i = 0; i < 50; i++) begin
            stop_ack_i = (i % 7 == 3);
            tick();
            checks++;
            if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
                errors++;
                $display("FAIL test_en_hold%0d got=%b exp=100", i, {clk_en_o, stop_req_o, gated_o});
            end
        end
        stop_ack_i = 1'b0;
        test_en_i = 1'b0;
        busy_i = 1'b1;
        tick();
        $display("test_test_en done");
    endtask

    task automatic test_async_reset();
        go_gated();
        #3;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
            errors++;
            $display("FAIL async_reset got=%b exp=100", {clk_en_o, stop_req_o, gated_o});
        end
        @(negedge clk_i);
        busy_i = 1'b1;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stop_ack_i = 1'b1;
            tick();
            checks++;
            if ({clk_en_o, stop_req_o, gated_o} !== 3'b100) begin
                errors++;
                $display("FAIL run_ack_ignored%0d got=%b exp=100", i, {clk_en_o, stop_req_o, gated_o});
            end
        end
        stop_ack_i = 1'b0;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_idle_to_gated();
        test_wake();
        test_count_restart();
        test_wake_ack_collision();
        test_test_en();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
